// File: rtl/matrix_pe.sv
// Matrix processing element: per micro-op, accumulates N paired 32-lane int16
// dot products from NRAM/WRAM beats and emits the low 32 bits of the sum.
module matrix_pe #(
  parameter int LANES  = 32,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 45,
  parameter int OUT_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [LANES*DATA_W-1:0]   nram_mpe_neuron,
  input  logic                      nram_mpe_neuron_valid,
  output logic                      nram_mpe_neuron_ready,
  input  logic [LANES*DATA_W-1:0]   wram_mpe_weight,
  input  logic                      wram_mpe_weight_valid,
  output logic                      wram_mpe_weight_ready,
  input  logic [7:0]                ib_ctl_uop,
  input  logic                      ib_ctl_uop_valid,
  output logic                      ib_ctl_uop_ready,
  output logic [OUT_W-1:0]          result,
  output logic                      vld_o
);

  // state | meaning
  // IDLE  | waiting for a micro-op, uop_ready high
  // CALC  | consuming paired neuron/weight beats
  // DONE  | single cycle, result valid and vld_o high
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [7:0]       n_q, n_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0] result_q, result_d;

  logic             pair_fire;
  logic             last_beat;
  logic [ACC_W-1:0] beat_sum;
  logic [ACC_W-1:0] acc_next;

  function automatic logic [ACC_W-1:0] beat_dot(
    input logic [LANES*DATA_W-1:0] a,
    input logic [LANES*DATA_W-1:0] b
  );
    logic signed [2*DATA_W-1:0] p;
    logic [ACC_W-1:0]           s;
    s = '0;
    for (int i = 0; i < LANES; i++) begin
      p = $signed(a[i*DATA_W +: DATA_W]) * $signed(b[i*DATA_W +: DATA_W]);
      s = s + {{(ACC_W-2*DATA_W){p[2*DATA_W-1]}}, p};
    end
    return s;
  endfunction

  // Both streams are accepted together only; a lone valid is never consumed.
  assign pair_fire = (state_q == CALC) && nram_mpe_neuron_valid && wram_mpe_weight_valid;
  assign nram_mpe_neuron_ready = pair_fire;
  assign wram_mpe_weight_ready = pair_fire;
  assign ib_ctl_uop_ready      = (state_q == IDLE);

  assign beat_sum  = beat_dot(nram_mpe_neuron, wram_mpe_weight);
  assign acc_next  = acc_q + beat_sum;
  assign last_beat = ({1'b0, cnt_q} + 9'd1) == {1'b0, n_q};

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (ib_ctl_uop_valid) begin
          n_d   = ib_ctl_uop;
          cnt_d = '0;
          acc_d = '0;
          if (ib_ctl_uop == 8'd0) begin
            state_d  = DONE;
            result_d = '0;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (pair_fire) begin
          acc_d = acc_next;
          cnt_d = cnt_q + 8'd1;
          if (last_beat) begin
            state_d  = DONE;
            result_d = acc_next[OUT_W-1:0];
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      n_q      <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;
  assign vld_o  = (state_q == DONE);

endmodule

// File: tb/tb_matrix_pe.sv
// Randomized bench for matrix_pe: beats are generated per micro-op, the golden
// result is the plain integer sum of all lane products, checked on every vld_o.
module tb_matrix_pe;
  localparam int LANES = 32;
  localparam int BW    = 512;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [BW-1:0] neuron, weight;
  logic          nv, nready, wv, wready;
  logic [7:0]    uop;
  logic          uv, uready;
  logic [31:0]   result;
  logic          vld_o;

  matrix_pe dut (
    .clk(clk), .rst_n(rst_n),
    .nram_mpe_neuron(neuron), .nram_mpe_neuron_valid(nv), .nram_mpe_neuron_ready(nready),
    .wram_mpe_weight(weight), .wram_mpe_weight_valid(wv), .wram_mpe_weight_ready(wready),
    .ib_ctl_uop(uop), .ib_ctl_uop_valid(uv), .ib_ctl_uop_ready(uready),
    .result(result), .vld_o(vld_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [BW-1:0] nb_q[$];
  logic [BW-1:0] wb_q[$];
  logic [31:0]   exp_res[$];
  int            exp_n[$];

  bit          mon_en = 1'b0;
  int          cyc = 0, uop_cyc = 0, last_fire = 0, cur_fires = 0, done_cnt = 0;
  logic [31:0] last_res = '0;
  logic [31:0] last_exp = '0;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic longint beat_dot(input logic [BW-1:0] a, input logic [BW-1:0] b);
    longint s = 0;
    for (int i = 0; i < LANES; i++)
      s += longint'($signed(a[16*i +: 16])) * longint'($signed(b[16*i +: 16]));
    return s;
  endfunction

  task automatic gen_const(input int n, input logic [15:0] a, input logic [15:0] b);
    nb_q.delete(); wb_q.delete();
    for (int k = 0; k < n; k++) begin
      nb_q.push_back({LANES{a}});
      wb_q.push_back({LANES{b}});
    end
  endtask

  task automatic gen_rand(input int n);
    logic [BW-1:0] x, y;
    nb_q.delete(); wb_q.delete();
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < BW/32; i++) begin
        x[32*i +: 32] = $urandom;
        y[32*i +: 32] = $urandom;
      end
      nb_q.push_back(x);
      wb_q.push_back(y);
    end
  endtask

  // Compare process: handshake rules every cycle, result/timing on every vld_o.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      cyc++;
      chk(nready == wready, "ready_pair", nready, wready);
      if (nready) chk(nv && wv, "no_lone_accept", {nv, wv}, 3);
      if (uv && uready) begin
        uop_cyc   = cyc;
        cur_fires = 0;
      end
      if (nv && nready) begin
        cur_fires++;
        last_fire = cyc;
      end
      if (vld_o) begin
        if (exp_res.size() == 0) begin
          chk(1'b0, "unexpected_vld", 1, 0);
        end else begin
          logic [31:0] er;
          int en;
          er = exp_res.pop_front();
          en = exp_n.pop_front();
          chk(result == er, "result", result, er);
          chk(cur_fires == en, "fire_count", cur_fires, en);
          if (en > 0) chk(cyc == last_fire + 1, "vld_after_last_fire", cyc - last_fire, 1);
          else        chk((cyc - uop_cyc) inside {1, 2}, "vld_after_n0_uop", cyc - uop_cyc, 1);
          last_res = result;
          done_cnt++;
        end
      end
    end
  end

  task automatic drive_uop(input int n, input bit stall);
    int guard = 0;
    if (stall) repeat ($urandom_range(0, 3)) @(posedge clk);
    @(posedge clk); #1;
    uv = 1'b1; uop = 8'(n);
    forever begin
      @(negedge clk);
      if (uready) break;
      guard++;
      if (guard > 2000) begin chk(1'b0, "uop_timeout", guard, 0); break; end
    end
    @(posedge clk); #1 uv = 1'b0;
  endtask

  task automatic drive_n(input int n, input bit stall);
    int idx = 0, guard = 0;
    bit hold = 1'b0;
    while (idx < n) begin
      @(posedge clk); #1;
      if (!hold) begin
        nv = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
        neuron = nb_q[idx];
      end
      @(negedge clk);
      if (nv && nready) begin idx++; hold = 1'b0; end
      else hold = nv;
      guard++;
      if (guard > 5000) begin chk(1'b0, "nram_timeout", idx, n); break; end
    end
    @(posedge clk); #1 nv = 1'b0;
  endtask

  task automatic drive_w(input int n, input bit stall);
    int idx = 0, guard = 0;
    bit hold = 1'b0;
    while (idx < n) begin
      @(posedge clk); #1;
      if (!hold) begin
        wv = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
        weight = wb_q[idx];
      end
      @(negedge clk);
      if (wv && wready) begin idx++; hold = 1'b0; end
      else hold = wv;
      guard++;
      if (guard > 5000) begin chk(1'b0, "wram_timeout", idx, n); break; end
    end
    @(posedge clk); #1 wv = 1'b0;
  endtask

  task automatic run_op(input int n, input bit stall);
    longint s = 0;
    int target, guard;
    for (int k = 0; k < n; k++) s += beat_dot(nb_q[k], wb_q[k]);
    last_exp = s[31:0];
    exp_res.push_back(s[31:0]);
    exp_n.push_back(n);
    target = done_cnt + 1;
    fork
      drive_uop(n, stall);
      drive_n(n, stall);
      drive_w(n, stall);
    join
    guard = 0;
    while (done_cnt < target && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    chk(done_cnt == target, "vld_timeout", done_cnt, target);
    repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  initial begin
    rst_n = 1'b0; uv = 1'b0; nv = 1'b0; wv = 1'b0;
    uop = '0; neuron = '0; weight = '0;
    repeat (2) @(posedge clk);
    #1;
    chk(result == 32'd0, "reset_result", result, 0);
    chk(vld_o == 1'b0, "reset_vld", vld_o, 0);
    chk(uready == 1'b1, "reset_uop_ready", uready, 1);
    chk(nready == 1'b0, "reset_nram_ready", nready, 0);
    @(negedge clk) rst_n = 1'b1;
    mon_en = 1'b1;

    gen_const(1, 16'd1, 16'd2);
    run_op(1, 1'b0);
    chk(last_exp == 32'd64, "model_all1x2", last_exp, 64);
    chk(last_res == 32'd64, "lit_all1x2", last_res, 64);

    gen_const(2, 16'hFFFF, 16'd3);
    run_op(2, 1'b1);
    chk(last_exp == 32'hFFFFFF40, "model_neg1x3", last_exp, 32'hFFFFFF40);
    chk(last_res == 32'hFFFFFF40, "lit_neg1x3", last_res, 32'hFFFFFF40);

    gen_const(0, 16'd0, 16'd0);
    run_op(0, 1'b1);
    chk(last_res == 32'd0, "lit_n0", last_res, 0);

    gen_rand(4);
    run_op(4, 1'b1);

    gen_const(255, 16'h8000, 16'h8000);
    run_op(255, 1'b0);
    chk(last_exp == 32'd0, "model_n255_min", last_exp, 0);
    chk(last_res == 32'd0, "lit_n255_min", last_res, 0);

    foreach (exp_n[i]) ;
    begin
      int lens[4] = '{30, 40, 50, 20};
      for (int k = 0; k < 4; k++) begin
        gen_rand(lens[k]);
        run_op(lens[k], 1'b1);
      end
    end

    // Abort mid-CALC: two beats of a five-beat op, then async reset.
    mon_en = 1'b0;
    @(posedge clk); #1 uv = 1'b1; uop = 8'd5;
    @(posedge clk); #1 uv = 1'b0;
    nv = 1'b1; wv = 1'b1;
    neuron = {LANES{16'd7}}; weight = {LANES{16'd9}};
    @(negedge clk);
    chk(nready == 1'b1, "calc_accepts_pair", nready, 1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk(result == 32'd0, "abort_result", result, 0);
    chk(vld_o == 1'b0, "abort_vld", vld_o, 0);
    chk(uready == 1'b1, "abort_uop_ready", uready, 1);
    chk(nready == 1'b0, "abort_nram_ready", nready, 0);
    @(negedge clk) rst_n = 1'b1;
    nv = 1'b0; wv = 1'b0;
    mon_en = 1'b1;
    repeat (4) @(negedge clk);
    chk(uready == 1'b1, "post_reset_uop_ready", uready, 1);
    chk(done_cnt == 9, "no_result_for_abort", done_cnt, 9);

    gen_rand(3);
    run_op(3, 1'b1);
    chk(exp_res.size() == 0, "all_results_seen", exp_res.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d checks expected completion", checks);
    $fatal(1, "timeout");
  end
endmodule
